// File: rtl/adc0809_scan_sched.sv
// ADC0809 round-robin scan scheduler. It walks the enabled channels, sequences ALE/START/EOC/OE and stores results in a bank.
// Latency: at least 7 phase ticks per conversion (SELECT..CAPTURE) plus 1 tick in IDLE; a tick is CLK_DIV clk.
// Backpressure: none. The read port never stalls the scan. An EOC timeout is built only with `define ADC_SCAN_TIMEOUT_EN.
module adc0809_scan_sched #(
  parameter int CLK_DIV       = 57,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] chan_mask,
  input  logic       eoc,
  input  logic [7:0] adc_data,
  output logic       ale,
  output logic       start,
  output logic       oe,
  output logic [2:0] addr,
  output logic       busy,
  output logic       sample_stb,
  output logic [2:0] sample_chan,
  output logic [7:0] sample_data,
  input  logic [2:0] rd_chan,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       err_clr,
  output logic       timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_ALE     = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;
  localparam logic [2:0] S_OE      = 3'd6;
  localparam logic [2:0] S_CAPTURE = 3'd7;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] DIV_MAX = PW'(CLK_DIV - 1);

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          eoc_meta;
  logic          eoc_sync;
  logic [2:0]    last_chan;
  logic          nxt_found;
  logic [2:0]    nxt_chan;
  logic          timeout_hit;
  logic          sel_fire;
  logic          cap_fire;
  logic [7:0]    bank [8];
  logic [7:0]    valid;

  assign tick     = (pre_cnt == DIV_MAX);
  assign busy     = (state != S_IDLE);
  assign sel_fire = tick && (state == S_SELECT) && nxt_found;
  assign cap_fire = tick && (state == S_CAPTURE);
  assign rd_data  = bank[rd_chan];
  assign rd_valid = valid[rd_chan];

  // Find the first enabled channel after 'last', searching upward and wrapping. Iterating from the far end lets the nearest hit win.
  function automatic logic [3:0] find_next(input logic [2:0] last, input logic [7:0] mask);
    logic [3:0] r;
    logic [2:0] c;
    r = 4'b0;
    for (int i = 8; i >= 1; i--) begin
      c = last + 3'(i);
      if (mask[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  assign {nxt_found, nxt_chan} = find_next(last_chan, chan_mask);

  // Phase prescaler. It is parked at 0 while idle with the scan disabled, so the first tick after enable comes one full period later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               pre_cnt <= '0;
    else if (state == S_IDLE && !enable)   pre_cnt <= '0;
    else if (tick)                         pre_cnt <= '0;
    else                                   pre_cnt <= pre_cnt + 1'b1;
  end

  // Two-flop synchronizer for the asynchronous EOC pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eoc_meta <= 1'b1;
      eoc_sync <= 1'b1;
    end else begin
      eoc_meta <= eoc;
      eoc_sync <= eoc_meta;
    end
  end

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS - 1);
  logic [TW-1:0] to_cnt;
  logic          to_expired;
  assign to_expired = (to_cnt == TO_MAX);

  // Ticks spent waiting on EOC. The count restarts on entry to WAIT_LO and runs on through WAIT_HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                      to_cnt <= '0;
    else if (tick && state == S_START)                            to_cnt <= '0;
    else if (tick && (state == S_WAIT_LO || state == S_WAIT_HI))  to_cnt <= to_cnt + 1'b1;
  end

  // Sticky timeout flag. A timeout that coincides with err_clr wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (err_clr)     timeout_err <= 1'b0;
  end
`else
  logic to_expired;
  logic unused_cfg;
  assign to_expired  = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = err_clr ^ (TIMEOUT_TICKS != 0);
`endif

  // Next-state decode. Every transition waits for a tick. If the mask goes empty during SELECT, the scan falls back to IDLE.
  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE:    if (enable && (chan_mask != 8'h00)) state_nx = S_SELECT;
        S_SELECT:  state_nx = nxt_found ? S_ALE : S_IDLE;
        S_ALE:     state_nx = S_START;
        S_START:   state_nx = S_WAIT_LO;
        S_WAIT_LO: begin
          if (to_expired) begin
            timeout_hit = 1'b1;
            state_nx    = S_IDLE;
          end else if (!eoc_sync) begin
            state_nx = S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (to_expired) begin
            timeout_hit = 1'b1;
            state_nx    = S_IDLE;
          end else if (eoc_sync) begin
            state_nx = S_OE;
          end
        end
        S_OE:      state_nx = S_CAPTURE;
        S_CAPTURE: state_nx = S_IDLE;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  // State register and pin strobes. The strobes decode from the next state, so they line up exactly with their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ale         <= 1'b0;
      start       <= 1'b0;
      oe          <= 1'b0;
      addr        <= 3'd0;
      last_chan   <= 3'd7;
      sample_stb  <= 1'b0;
      sample_chan <= 3'd0;
      sample_data <= 8'h00;
    end else begin
      state      <= state_nx;
      ale        <= (state_nx == S_ALE);
      start      <= (state_nx == S_START);
      oe         <= (state_nx == S_OE) || (state_nx == S_CAPTURE);
      sample_stb <= cap_fire;
      if (sel_fire) addr <= nxt_chan;
      if (cap_fire) begin
        sample_chan <= addr;
        sample_data <= adc_data;
      end
      if (cap_fire || timeout_hit) last_chan <= addr;
    end
  end

  // Result bank. It is written on the capture tick, so a same-clk read still returns the previous value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
      valid <= 8'h00;
    end else if (cap_fire) begin
      bank[addr]  <= adc_data;
      valid[addr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc0809_scan_sched.sv
// Bench for adc0809_scan_sched with CLK_DIV=4 and TIMEOUT_TICKS=10, driven by a behavioural ADC0809 model.
// Expected channels come from the round-robin rule over the mask. Expected data comes from the values the ADC model was told to return.
// Every step runs in one initial block, and every wait has a cycle budget.
module tb_adc0809_scan_sched;
  localparam int CD = 4;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst, enable, eoc, err_clr;
  logic [7:0] chan_mask, adc_data;
  logic [2:0] rd_chan;
  logic       ale, start, oe, busy, sample_stb, rd_valid, timeout_err;
  logic [2:0] addr, sample_chan;
  logic [7:0] sample_data, rd_data;

  int errors = 0;
  int checks = 0;

  // ADC model controls and scoreboard state
  logic [7:0] chan_val [8];
  logic [7:0] stuck_mask;
  int         low_ticks;
  logic [7:0] m_bank [8];
  logic [7:0] m_valid;
  int         m_last;
  bit         drop_en;

  adc0809_scan_sched #(.CLK_DIV(CD), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .chan_mask(chan_mask), .eoc(eoc),
    .adc_data(adc_data), .ale(ale), .start(start), .oe(oe), .addr(addr),
    .busy(busy), .sample_stb(sample_stb), .sample_chan(sample_chan),
    .sample_data(sample_data), .rd_chan(rd_chan), .rd_data(rd_data),
    .rd_valid(rd_valid), .err_clr(err_clr), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ADC0809 model. It latches the address at the end of START, then pulls EOC low for a while and presents the data when EOC returns high.
  initial begin
    logic [2:0] lat;
    eoc = 1'b1;
    adc_data = 8'h00;
    @(negedge rst);
    forever begin
      @(negedge start);
      if (!rst) begin
        lat = addr;
        if (!stuck_mask[lat]) begin
          #2 eoc = 1'b0;
          repeat (low_ticks * CD + $urandom_range(0, 3)) @(posedge clk);
          #2;
          adc_data = chan_val[lat];
          eoc = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int next_ch(input int last, input logic [7:0] m);
    for (int i = 1; i <= 8; i++) if (m[(last + i) % 8]) return (last + i) % 8;
    return 0;
  endfunction

  // Run one conversion, expecting channel exp_ch, then check the strobe, the phase widths and the read port.
  task automatic do_conv(input int exp_ch);
    int ale_n = 0, start_n = 0, oe_n = 0, both = 0, cyc = 0;
    bit got = 0;
    logic [2:0] r;
    while (!got && cyc < CD * 80) begin
      @(posedge clk); #1;
      cyc++;
      if (drop_en && eoc == 1'b0) enable = 1'b0;
      ale_n += int'(ale);
      start_n += int'(start);
      oe_n += int'(oe);
      if (ale && start) both++;
      if (sample_stb) got = 1;
    end
    chk("stb_seen", 32'(got), 32'd1);
    chk("sample_chan", 32'(sample_chan), 32'(exp_ch));
    chk("sample_data", 32'(sample_data), 32'(chan_val[exp_ch]));
    chk("ale_width", 32'(ale_n), 32'(CD));
    chk("start_width", 32'(start_n), 32'(CD));
    chk("oe_width", 32'(oe_n), 32'(2 * CD));
    chk("ale_start_excl", 32'(both), 32'd0);
    m_bank[exp_ch] = chan_val[exp_ch];
    m_valid[exp_ch] = 1'b1;
    m_last = exp_ch;
    @(posedge clk); #1;
    chk("stb_one_clk", 32'(sample_stb), 32'd0);
    r = 3'($urandom_range(0, 7));
    rd_chan = r;
    #1;
    chk("rd_valid_rand", 32'(rd_valid), 32'(m_valid[r]));
    if (m_valid[r]) chk("rd_data_rand", 32'(rd_data), 32'(m_bank[r]));
    rd_chan = 3'(exp_ch);
    #1;
    chk("rd_valid_cap", 32'(rd_valid), 32'd1);
    chk("rd_data_cap", 32'(rd_data), 32'(chan_val[exp_ch]));
  endtask

  initial begin
    int n, cnt, stb_n;
    bit seen;
    rst = 1'b1; enable = 1'b0; chan_mask = 8'h00; err_clr = 1'b0; rd_chan = 3'd0;
    stuck_mask = 8'h00; low_ticks = 3; drop_en = 0;
    m_valid = 8'h00; m_last = 7;
    for (int i = 0; i < 8; i++) begin
      chan_val[i] = 8'hA0 + 8'(i);
      m_bank[i] = 8'h00;
    end

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_ale", 32'(ale), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_oe", 32'(oe), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stb", 32'(sample_stb), 0);
    chk("rst_schan", 32'(sample_chan), 0);
    chk("rst_sdata", 32'(sample_data), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_rdvalid", 32'(rd_valid), 0);
    rst = 1'b0;

    // With an empty mask the scheduler never leaves IDLE
    enable = 1'b1;
    cnt = 0;
    repeat (20 * CD) begin
      @(posedge clk); #1;
      if (busy || ale || start || oe || sample_stb) cnt++;
    end
    chk("mask0_idle", 32'(cnt), 0);

    // Directed scan over mask 05: channel sequence 0,2,0,2 with data A0+channel
    chan_mask = 8'h05;
    do_conv(0);
    do_conv(2);
    do_conv(0);
    do_conv(2);

    // Random masks, data and EOC low times
    repeat (6) begin
      chan_mask = 8'($urandom_range(1, 255));
      for (int i = 0; i < 8; i++) chan_val[i] = 8'($urandom);
      repeat (4) begin
        low_ticks = $urandom_range(2, 5);
        do_conv(next_ch(m_last, chan_mask));
      end
    end

    // Drop enable while channel 3 is converting: the capture still completes, then the scheduler stays idle
    low_ticks = 3;
    chan_mask = 8'h08;
    drop_en = 1;
    do_conv(3);
    drop_en = 0;
    cnt = 0;
    repeat (12 * CD) begin
      @(posedge clk); #1;
      if (busy || sample_stb) cnt++;
    end
    chk("drop_en_idle", 32'(cnt), 0);

    // Assert reset during OE: outputs clear at once, then the scan restarts at the lowest enabled channel
    chan_mask = 8'h0C;
    enable = 1'b1;
    seen = 0; n = 0;
    while (!seen && n < CD * 80) begin
      @(posedge clk); #1; n++;
      if (oe) seen = 1;
    end
    chk("oe_reached", 32'(seen), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_oe", 32'(oe), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_schan", 32'(sample_chan), 0);
    chk("mid_rst_sdata", 32'(sample_data), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rd_chan = 3'(i);
      #1;
      cnt += int'(rd_valid);
    end
    chk("mid_rst_valid", 32'(cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_valid = 8'h00; m_last = 7;
    for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
    do_conv(2);

    // EOC stuck high on channel 1 with mask 03
    chan_mask = 8'h03;
    do_conv(next_ch(m_last, chan_mask));
    stuck_mask = 8'h02;
`ifdef ADC_SCAN_TIMEOUT_EN
    seen = 0; n = 0;
    while (!seen && n < CD * 80) begin
      @(posedge clk); #1; n++;
      if (start) seen = 1;
    end
    while (seen && start && n < CD * 80) begin
      @(posedge clk); #1; n++;
    end
    chk("stuck_start", 32'(seen), 1);
    n = 0; stb_n = 0;
    while (!timeout_err && n < CD * 40) begin
      @(posedge clk); #1; n++;
      stb_n += int'(sample_stb);
    end
    chk("to_latency", 32'(n), 32'(TO * CD));
    chk("to_no_stb", 32'(stb_n), 0);
    chk("to_idle", 32'(busy), 0);
    m_last = 1;
    stuck_mask = 8'h00;
    do_conv(next_ch(m_last, chan_mask));
    chk("to_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("to_cleared", 32'(timeout_err), 0);
`else
    stb_n = 0; cnt = 0;
    err_clr = 1'b1;
    repeat (30 * CD) begin
      @(posedge clk); #1;
      stb_n += int'(sample_stb);
      cnt += int'(timeout_err);
    end
    err_clr = 1'b0;
    chk("stuck_busy", 32'(busy), 1);
    chk("stuck_no_oe", 32'(oe), 0);
    chk("stuck_no_stb", 32'(stb_n), 0);
    chk("stuck_no_terr", 32'(cnt), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
